// File: rtl/fifo_nibble_tx.sv
// Nibble FIFO read-side drain: pops words and sends them as UART frames on tx.
// Optional even-parity bit after the data field: define FIFO_TX_PARITY_EN.
module fifo_nibble_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int RD_LAT       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0] WAIT_TC = WW'(RD_LAT - 1);
  localparam logic [IW-1:0] IDX_TC  = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [BW-1:0]         baud;
  logic [WW-1:0]         wcnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0] data;
  logic                  tx_nxt;
  logic                  baud_tc;
  logic                  wait_tc;
  logic                  pop_ok;
  logic                  in_bit;

  assign baud_tc = (baud == BAUD_TC);
  assign wait_tc = (wcnt == WAIT_TC);
  assign pop_ok  = en && !empty;

  assign in_bit = (state == S_START)
`ifdef FIFO_TX_PARITY_EN
               || (state == S_PARITY)
`endif
               || (state == S_DATA)
               || (state == S_STOP);

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_STOP) && baud_tc;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (pop_ok) state_nxt = S_POP;
      end
      S_POP: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_tc) state_nxt = S_START;
      end
      S_START: begin
        if (baud_tc) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (baud_tc) begin
          if (idx == IDX_TC) begin
            idx_nxt = '0;
`ifdef FIFO_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tc) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_tc) state_nxt = pop_ok ? S_POP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx is computed for the state being entered so the line is registered
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = data[idx_nxt];
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: tx_nxt = ^data;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      baud  <= '0;
      wcnt  <= '0;
      idx   <= '0;
      data  <= '0;
      tx    <= 1'b1;
      rinc  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tx    <= tx_nxt;
      rinc  <= (state_nxt == S_POP);
      if (in_bit) begin
        baud <= baud_tc ? '0 : baud + BW'(1);
      end else begin
        baud <= '0;
      end
      if (state == S_WAIT) begin
        wcnt <= wait_tc ? '0 : wcnt + WW'(1);
      end else begin
        wcnt <= '0;
      end
      if (state == S_WAIT && wait_tc) begin
        data <= rdata;
      end
    end
  end

endmodule
